// File: rtl/axis_to_pull_pkg.sv
// Shared definitions for the axis_to_pull stream-to-pull FIFO.
//   DEF_WIDTH / DEF_SIZE_LOG2 : default data width and log2 RAM depth
//   aempty_default()          : default almost-empty threshold, half the RAM depth
package axis_to_pull_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_SIZE_LOG2 = 4;

  function automatic int unsigned aempty_default(input int unsigned size_log2);
    return 32'd1 << (size_log2 - 32'd1);
  endfunction

endpackage

// File: rtl/axis_to_pull_ram.sv
// Simple dual-port distributed RAM with one write port and a registered read port.
//   clock   : write and read clock (rising edge)
//   wenable : write strobe; wdata is stored at waddr
//   renable : read strobe; rdata loads mem[raddr] and holds otherwise
//   rdata   : registered read data, not reset
module axis_to_pull_ram #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              wenable,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              renable,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (renable) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clock) begin
    if (wenable) mem_q[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axis_to_pull.sv
// AXI-stream to pull-interface FIFO. Stream words are written into a RAM and the
// head word is kept in a registered output stage the consumer strobes away.
//   clock, resetn   : single rising-edge clock, asynchronous active-low reset
//   idata/ivalid/iready : stream input; iready depends on registers only
//   odata/oempty    : head word, valid while oempty=0
//   oenable         : consumer takes odata this cycle
//   oaempty         : registered almost-empty flag (RAM count < AEMPTY_LIMIT)
//   underflow       : sticky, set by oenable while oempty, cleared by reset only
//   ocount          : total words held (RAM + output register); present only
//                     when AXIS_TO_PULL_COUNT_EN is defined
module axis_to_pull
  import axis_to_pull_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned SIZE_LOG2    = DEF_SIZE_LOG2,
  parameter int unsigned AEMPTY_LIMIT = aempty_default(SIZE_LOG2)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] idata,
  input  logic             ivalid,
  output logic             iready,
  output logic [WIDTH-1:0] odata,
  output logic             oempty,
  input  logic             oenable,
  output logic             oaempty,
  output logic             underflow
`ifdef AXIS_TO_PULL_COUNT_EN
  ,
  output logic [SIZE_LOG2:0] ocount
`endif
);

  localparam logic [SIZE_LOG2:0] AEMPTY_W = (SIZE_LOG2+1)'(AEMPTY_LIMIT);

  logic [SIZE_LOG2-1:0] waddr_q, waddr_d;
  logic [SIZE_LOG2-1:0] raddr_q, raddr_d;
  logic                 ovalid_q, ovalid_d;
  logic                 oaempty_q, oaempty_d;
  logic                 underflow_q, underflow_d;

  logic [SIZE_LOG2-1:0] size;
  logic                 wenable;
  logic                 renable;

  always_comb begin
    size    = waddr_q - raddr_q;
    iready  = ~&size;
    wenable = ivalid & iready;
    // Refill the output register whenever it is free or being taken this cycle.
    renable = (|size) & (~ovalid_q | oenable);

    waddr_d     = wenable ? waddr_q + SIZE_LOG2'(1) : waddr_q;
    raddr_d     = renable ? raddr_q + SIZE_LOG2'(1) : raddr_q;
    ovalid_d    = renable | (ovalid_q & ~oenable);
    oaempty_d   = {1'b0, size} < AEMPTY_W;
    underflow_d = underflow_q | (oenable & ~ovalid_q);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      waddr_q     <= '0;
      raddr_q     <= '0;
      ovalid_q    <= 1'b0;
      oaempty_q   <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      ovalid_q    <= ovalid_d;
      oaempty_q   <= oaempty_d;
      underflow_q <= underflow_d;
    end
  end

  axis_to_pull_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (SIZE_LOG2)
  ) u_ram (
    .clock   (clock),
    .wenable (wenable),
    .waddr   (waddr_q),
    .wdata   (idata),
    .renable (renable),
    .raddr   (raddr_q),
    .rdata   (odata)
  );

  always_comb begin
    oempty    = ~ovalid_q;
    oaempty   = oaempty_q;
    underflow = underflow_q;
  end

`ifdef AXIS_TO_PULL_COUNT_EN
  always_comb ocount = {1'b0, size} + {{SIZE_LOG2{1'b0}}, ovalid_q};
`endif

endmodule

// File: tb/tb_axis_to_pull.sv
module tb_axis_to_pull;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] idata = 8'h00;
  logic       ivalid = 1'b0;
  logic       oenable = 1'b0;
  logic       iready;
  logic [7:0] odata;
  logic       oempty;
  logic       oaempty;
  logic       underflow;
`ifdef AXIS_TO_PULL_COUNT_EN
  logic [4:0] ocount;
`endif

  axis_to_pull #(
    .WIDTH     (8),
    .SIZE_LOG2 (4)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .idata     (idata),
    .ivalid    (ivalid),
    .iready    (iready),
    .odata     (odata),
    .oempty    (oempty),
    .oenable   (oenable),
    .oaempty   (oaempty),
    .underflow (underflow)
`ifdef AXIS_TO_PULL_COUNT_EN
    ,
    .ocount    (ocount)
`endif
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  int         popped = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard input side: every accepted stream word is expected at the pull side.
  always @(negedge clock) begin
    if (resetn && ivalid && iready) exp_q.push_back(idata);
  end

  // Monitor: every pull of a non-empty head is compared against the scoreboard.
  always @(negedge clock) begin
    if (resetn && oenable && !oempty) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pull_unexpected: got 0x%0h expected no word", odata);
      end else begin
        check("pull_data", {24'h0, odata}, {24'h0, exp_q.pop_front()});
        popped++;
      end
    end
  end

  always @(negedge resetn) exp_q.delete();

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int p0;
    int sent;

    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    @(posedge clock); #1;

    // 1: idle after reset
    check("rst_iready", iready, 1);
    check("rst_oempty", oempty, 1);
    check("rst_oaempty", oaempty, 1);
    check("rst_underflow", underflow, 0);

    // 2: single word, one-cycle latency to the output register
    idata = 8'hA5; ivalid = 1'b1;
    @(posedge clock); #1;
    ivalid = 1'b0;
    check("lat_not_yet", oempty, 1);
    @(posedge clock); #1;
    check("lat_oempty", oempty, 0);
    check("lat_odata", {24'h0, odata}, 32'hA5);
    p0 = popped;
    oenable = 1'b1;
    @(posedge clock); #1;
    oenable = 1'b0;
    check("single_pop", popped - p0, 1);
    check("single_empty", oempty, 1);

    // 3: fill with no consumer; capacity is RAM-1 plus the output register
    d = 0;
    for (int c = 0; c < 22; c++) begin
      idata  = d[7:0];
      ivalid = (d <= 20);
      @(negedge clock);
      if (ivalid && iready) d++;
      @(posedge clock); #1;
    end
    ivalid = 1'b0;
    check("fill_count", d, 16);
    check("fill_iready", iready, 0);
    check("fill_odata", {24'h0, odata}, 32'h00);
    check("fill_oempty", oempty, 0);
    check("fill_oaempty", oaempty, 0);
`ifdef AXIS_TO_PULL_COUNT_EN
    check("fill_ocount", ocount, 16);
`endif
    p0 = popped;
    for (int c = 0; c < 60 && (popped - p0) < 16; c++) begin
      oenable = !oempty;
      @(posedge clock); #1;
    end
    oenable = 1'b0;
    check("drain_count", popped - p0, 16);
    check("drain_oaempty", oaempty, 1);

    // 4: random valid/enable, 200 words in order
    sent = 0;
    p0 = popped;
    for (int c = 0; c < 5000 && (popped - p0) < 200; c++) begin
      idata   = sent[7:0];
      ivalid  = (sent < 200) && ($urandom_range(0, 1) == 1);
      oenable = !oempty && ($urandom_range(0, 1) == 1);
      @(negedge clock);
      if (ivalid && iready) sent++;
      @(posedge clock); #1;
    end
    ivalid = 1'b0; oenable = 1'b0;
    check("rand_received", popped - p0, 200);
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_underflow", underflow, 0);

    // 5: pull while empty sets sticky underflow
    check("uf_pre_empty", oempty, 1);
    oenable = 1'b1;
    @(posedge clock); #1;
    oenable = 1'b0;
    check("uf_set", underflow, 1);
    check("uf_still_empty", oempty, 1);
    idata = 8'h11; ivalid = 1'b1;
    @(posedge clock); #1;
    ivalid = 1'b0;
    @(posedge clock); #1;
    p0 = popped;
    oenable = 1'b1;
    @(posedge clock); #1;
    oenable = 1'b0;
    check("uf_traffic_pop", popped - p0, 1);
    check("uf_sticky", underflow, 1);
    resetn = 1'b0;
    #1;
    check("uf_cleared", underflow, 0);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;

    // 6: asynchronous reset discards buffered words
    for (int i = 0; i < 5; i++) begin
      idata = 8'h50 + 8'(i); ivalid = 1'b1;
      @(posedge clock); #1;
    end
    ivalid = 1'b0;
    @(posedge clock); #1;
    check("pre_rst_oempty", oempty, 0);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_oempty", oempty, 1);
    check("mid_rst_iready", iready, 1);
    check("mid_rst_oaempty", oaempty, 1);
`ifdef AXIS_TO_PULL_COUNT_EN
    check("mid_rst_ocount", ocount, 0);
`endif
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    idata = 8'h3C; ivalid = 1'b1;
    @(posedge clock); #1;
    ivalid = 1'b0;
    @(posedge clock); #1;
    check("post_rst_oempty", oempty, 0);
    check("post_rst_odata", {24'h0, odata}, 32'h3C);
    p0 = popped;
    oenable = 1'b1;
    @(posedge clock); #1;
    oenable = 1'b0;
    check("post_rst_pop", popped - p0, 1);
    check("post_rst_empty", oempty, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
